// File: rtl/hls_mon_pkg.sv
// rtl/hls_mon_pkg.sv - shared types, default widths and saturating increment helper for hls_loop_monitor
package hls_mon_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } mod_state_e;

  // Counter widths up to 64 bits share one helper; callers widen and narrow around it.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
    return (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/hls_mon_sat_counter.sv
// rtl/hls_mon_sat_counter.sv - saturating event counter with freeze input
module hls_mon_sat_counter
  import hls_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count qualified events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !freeze) begin
      r_count <= CNT_W'(sat_inc(64'(r_count), 64'({CNT_W{1'b1}})));
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hls_loop_monitor.sv
// rtl/hls_loop_monitor.sv - activity monitor for one HLS function and one pipelined loop; optional macro HLS_MON_STALL_EN builds the stall counter
module hls_loop_monitor
  import hls_mon_pkg::*;
#(
  parameter int STATE_W = 1,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cnt,
  output logic [CNT_W-1:0]   loop_iter_start_cnt,
  output logic [CNT_W-1:0]   loop_iter_end_cnt,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   loop_stall_cnt,
  output logic [CNT_W-1:0]   loop_inflight,
  output logic               frozen
);

  mod_state_e r_state;

  logic w_run;
  logic w_freeze;
  logic w_mod_start;
  logic w_mod_done;
  logic w_iter_start;
  logic w_iter_end;
  logic w_quit_ok;
  logic w_loop_inv;
  logic w_unused;

  assign w_run        = (r_state == RUN);
  assign w_freeze     = (r_state == FROZEN);
  assign w_mod_start  = ap_start & ap_ready;
  assign w_mod_done   = ap_done & ap_continue;
  assign w_iter_start = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
  assign w_iter_end   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
  assign w_quit_ok    = (cur_state == quit_state) & quit_enable & ~quit_block;
  assign w_loop_inv   = loop_done & loop_continue & (~quit_at_end | w_quit_ok);

  // Module FSM; finish wins over every handshake and FROZEN is left only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (finish) begin
      r_state <= FROZEN;
    end else begin
      case (r_state)
        IDLE:    if (ap_start) r_state <= RUN;
        RUN:     if (ap_done && ap_continue && !ap_start) r_state <= IDLE;
        FROZEN:  r_state <= FROZEN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mod_busy = w_run;
  assign frozen   = w_freeze;

  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_mod_start (
    .clock(clock), .reset(reset), .inc(w_mod_start), .freeze(w_freeze), .count(mod_start_cnt));
  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_mod_done (
    .clock(clock), .reset(reset), .inc(w_mod_done), .freeze(w_freeze), .count(mod_done_cnt));
  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_mod_busy (
    .clock(clock), .reset(reset), .inc(w_run), .freeze(w_freeze), .count(mod_busy_cnt));
  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_iter_start (
    .clock(clock), .reset(reset), .inc(w_iter_start), .freeze(w_freeze), .count(loop_iter_start_cnt));
  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_iter_end (
    .clock(clock), .reset(reset), .inc(w_iter_end), .freeze(w_freeze), .count(loop_iter_end_cnt));
  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_loop_inv (
    .clock(clock), .reset(reset), .inc(w_loop_inv), .freeze(w_freeze), .count(loop_inv_cnt));

  // In-flight is a raw modulo difference, so it keeps wrapping even when an operand saturates.
  assign loop_inflight = loop_iter_start_cnt - loop_iter_end_cnt;

`ifdef HLS_MON_STALL_EN
  logic r_loop_active;
  logic w_stall;

  // Loop active window; a new loop_start beats a coinciding invocation end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loop_active <= 1'b0;
    end else if (loop_start) begin
      r_loop_active <= 1'b1;
    end else if (w_loop_inv) begin
      r_loop_active <= 1'b0;
    end
  end

  assign w_stall = r_loop_active & (cur_state == iter_start_state) & iter_start_block;

  hls_mon_sat_counter #(.CNT_W(CNT_W)) u_loop_stall (
    .clock(clock), .reset(reset), .inc(w_stall), .freeze(w_freeze), .count(loop_stall_cnt));

  assign w_unused = &{1'b0, loop_ready};
`else
  assign loop_stall_cnt = '0;
  assign w_unused       = &{1'b0, loop_ready, loop_start};
`endif

endmodule

// File: tb/tb_hls_loop_monitor.sv
// tb/tb_hls_loop_monitor.sv - self-checking bench for hls_loop_monitor
module tb_hls_loop_monitor;

  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset, finish;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic mod_busy, frozen;
  logic [CW-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cnt;
  logic [CW-1:0] loop_iter_start_cnt, loop_iter_end_cnt, loop_inv_cnt, loop_stall_cnt, loop_inflight;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic cs, ss, es, se, sb, ee, eb;
    int   exp_s, exp_e, exp_if;
  } vec_t;
  vec_t vecs[10];

  always #5 clock = ~clock;

  hls_loop_monitor #(.STATE_W(1), .CNT_W(CW)) u_dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .quit_state(quit_state), .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end), .mod_busy(mod_busy),
    .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt), .mod_busy_cnt(mod_busy_cnt),
    .loop_iter_start_cnt(loop_iter_start_cnt), .loop_iter_end_cnt(loop_iter_end_cnt),
    .loop_inv_cnt(loop_inv_cnt), .loop_stall_cnt(loop_stall_cnt), .loop_inflight(loop_inflight),
    .frozen(frozen));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_loop(input logic cs, ss, es, se, sb, ee, eb);
    cur_state = cs; iter_start_state = ss; iter_end_state = es;
    iter_start_enable = se; iter_start_block = sb;
    iter_end_enable = ee; iter_end_block = eb;
  endtask

  task automatic clear_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    set_loop(0, 0, 0, 0, 0, 0, 0);
    quit_state = 1; quit_block = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, mod_start_cnt, 0);
    chk({tag, "_done"}, mod_done_cnt, 0);
    chk({tag, "_busy_cnt"}, mod_busy_cnt, 0);
    chk({tag, "_iter_s"}, loop_iter_start_cnt, 0);
    chk({tag, "_iter_e"}, loop_iter_end_cnt, 0);
    chk({tag, "_inv"}, loop_inv_cnt, 0);
    chk({tag, "_stall"}, loop_stall_cnt, 0);
    chk({tag, "_inflight"}, loop_inflight, 0);
    chk({tag, "_mod_busy"}, mod_busy, 0);
    chk({tag, "_frozen"}, frozen, 0);
  endtask

  initial begin
    int exp_stall;
    //          cs ss es se sb ee eb   s  e  if
    vecs[0] = '{0, 0, 0, 1, 0, 1, 0,   1, 1, 0};
    vecs[1] = '{0, 0, 0, 1, 0, 1, 0,   2, 2, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 0, 0,   3, 2, 1};
    vecs[3] = '{0, 0, 0, 1, 0, 1, 1,   4, 2, 2};
    vecs[4] = '{1, 0, 0, 1, 0, 1, 0,   4, 2, 2};
    vecs[5] = '{0, 0, 0, 0, 0, 1, 0,   4, 3, 1};
    vecs[6] = '{0, 0, 0, 1, 1, 1, 0,   4, 4, 0};
    vecs[7] = '{0, 0, 0, 1, 0, 1, 0,   5, 5, 0};
    vecs[8] = '{1, 1, 0, 1, 0, 1, 0,   6, 5, 1};
    vecs[9] = '{1, 0, 1, 1, 0, 1, 0,   6, 6, 0};

    // Reset state
    do_reset();
    chk_all_zero("rst");

    // Iteration event table
    for (int i = 0; i < 10; i++) begin
      set_loop(vecs[i].cs, vecs[i].ss, vecs[i].es, vecs[i].se, vecs[i].sb, vecs[i].ee, vecs[i].eb);
      tick();
      chk($sformatf("vec%0d_iter_s", i), loop_iter_start_cnt, vecs[i].exp_s);
      chk($sformatf("vec%0d_iter_e", i), loop_iter_end_cnt, vecs[i].exp_e);
      chk($sformatf("vec%0d_inflight", i), loop_inflight, vecs[i].exp_if);
    end
    chk("vec_stall_inactive", loop_stall_cnt, 0);

    // Module transaction: start, 10 busy cycles, done
    do_reset();
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    chk("txn_mod_busy_run", mod_busy, 1);
    chk("txn_start_cnt", mod_start_cnt, 1);
    for (int i = 0; i < 9; i++) tick();
    ap_done = 1; ap_continue = 1;
    tick();
    ap_done = 0; ap_continue = 0;
    chk("txn_start_cnt_end", mod_start_cnt, 1);
    chk("txn_done_cnt", mod_done_cnt, 1);
    chk("txn_busy_cnt", mod_busy_cnt, 10);
    chk("txn_mod_busy_idle", mod_busy, 0);

    // Back-to-back: done with a new start keeps RUN
    ap_start = 1; ap_ready = 1;
    tick();
    ap_done = 1; ap_continue = 1;
    tick();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    chk("b2b_mod_busy", mod_busy, 1);
    chk("b2b_start_cnt", mod_start_cnt, 3);
    chk("b2b_done_cnt", mod_done_cnt, 2);
    chk("b2b_busy_cnt", mod_busy_cnt, 11);

    // Eight clean iterations
    do_reset();
    set_loop(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    set_loop(0, 0, 0, 0, 0, 0, 0);
    chk("clean8_iter_s", loop_iter_start_cnt, 8);
    chk("clean8_iter_e", loop_iter_end_cnt, 8);
    chk("clean8_inflight", loop_inflight, 0);

    // Stalls inside an active loop
    do_reset();
    loop_start = 1;
    tick();
    loop_start = 0;
    for (int i = 0; i < 8; i++) begin
      set_loop(0, 0, 0, 1, (i == 2 || i == 3 || i == 5), 1, 0);
      tick();
    end
    set_loop(0, 0, 0, 0, 0, 0, 0);
`ifdef HLS_MON_STALL_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    chk("stall_iter_s", loop_iter_start_cnt, 5);
    chk("stall_iter_e", loop_iter_end_cnt, 8);
    chk("stall_inflight", loop_inflight, 13);
    chk("stall_cnt", loop_stall_cnt, exp_stall);

    // Loop invocation with and without quit qualification
    do_reset();
    quit_at_end = 1; cur_state = 1; quit_state = 1;
    loop_done = 1; loop_continue = 1; quit_enable = 0;
    tick();
    loop_done = 0; loop_continue = 0;
    chk("inv_quit_dis", loop_inv_cnt, 0);
    loop_done = 1; loop_continue = 1; quit_enable = 1;
    tick();
    loop_done = 0; loop_continue = 0;
    chk("inv_quit_en", loop_inv_cnt, 1);
    quit_block = 1; loop_done = 1; loop_continue = 1;
    tick();
    loop_done = 0; loop_continue = 0; quit_block = 0;
    chk("inv_quit_blk", loop_inv_cnt, 1);
    quit_at_end = 0; quit_enable = 0; cur_state = 0;
    loop_done = 1; loop_continue = 1;
    tick();
    chk("inv_no_quit", loop_inv_cnt, 2);
    loop_continue = 0;
    tick();
    loop_done = 0;
    chk("inv_no_cont", loop_inv_cnt, 2);

    // Saturation at CNT_W=4
    do_reset();
    set_loop(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    set_loop(0, 0, 0, 0, 0, 0, 0);
    chk("sat_iter_s", loop_iter_start_cnt, 15);
    chk("sat_inflight", loop_inflight, 15);

    // In-flight wraps below zero
    do_reset();
    set_loop(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    set_loop(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_iter_e", loop_iter_end_cnt, 3);
    chk("wrap_inflight", loop_inflight, 13);

    // Finish during RUN freezes everything
    do_reset();
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    finish = 1;
    set_loop(0, 0, 0, 1, 0, 0, 0);
    tick();
    finish = 0;
    chk("fin_frozen", frozen, 1);
    chk("fin_mod_busy", mod_busy, 0);
    chk("fin_busy_cnt", mod_busy_cnt, 5);
    chk("fin_iter_s", loop_iter_start_cnt, 1);
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    loop_done = 1; loop_continue = 1;
    set_loop(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("frz_frozen", frozen, 1);
    chk("frz_mod_busy", mod_busy, 0);
    chk("frz_start_cnt", mod_start_cnt, 1);
    chk("frz_done_cnt", mod_done_cnt, 0);
    chk("frz_busy_cnt", mod_busy_cnt, 5);
    chk("frz_iter_s", loop_iter_start_cnt, 1);
    chk("frz_iter_e", loop_iter_end_cnt, 0);
    chk("frz_inv", loop_inv_cnt, 0);

    // Asynchronous reset clears without a clock edge; finish ignored during reset
    clear_inputs();
    finish = 1;
    reset = 1;
    #2;
    chk_all_zero("arst");
    tick();
    finish = 0;
    reset = 0;
    tick();
    chk("arst_frozen_after", frozen, 0);
    set_loop(0, 0, 0, 1, 0, 0, 0);
    tick();
    set_loop(0, 0, 0, 0, 0, 0, 0);
    chk("arst_resume_iter_s", loop_iter_start_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_loop_monitor.md
# hls_loop_monitor

Synthesizable activity monitor for one HLS-generated function and one pipelined loop inside it. Observes the block-level handshake (ap_start/ap_ready/ap_done/ap_continue) and the loop FSM state, pipeline enables and stall flags. Produces saturating counters for transactions, busy cycles, iterations and stalls. Sits beside the instrumented kernel in the simulation/debug top and is read out after `finish`.

## Interface
- STATE_W, 1: width of the loop FSM state vector.
- CNT_W, 32: width of every counter output.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- finish  in  1  end of test; freezes all counters (sticky).
- ap_start, ap_ready, ap_done, ap_continue  in  1 each  module handshake.
- cur_state  in  STATE_W  loop FSM current state.
- iter_start_state, iter_end_state, quit_state  in  STATE_W  reference state encodings.
- iter_start_block, iter_end_block, quit_block  in  1 each  stage stall flags; 1 = stalled.
- iter_start_enable, iter_end_enable, quit_enable  in  1 each  pipeline stage valid.
- loop_start, loop_ready, loop_done, loop_continue, quit_at_end  in  1 each  loop handshake.
- mod_busy  out  1  module state is RUN.
- mod_start_cnt, mod_done_cnt, mod_busy_cnt  out  CNT_W  module starts accepted, completions, busy cycles.
- loop_iter_start_cnt, loop_iter_end_cnt, loop_inv_cnt, loop_stall_cnt  out  CNT_W  loop counters.
- loop_inflight  out  CNT_W  iter_start_cnt minus iter_end_cnt, modulo 2^CNT_W.
- frozen  out  1  finish has been seen.

## Operation
- Module FSM states: IDLE, RUN, FROZEN.
  - IDLE to RUN on ap_start.
  - RUN to IDLE on ap_done & ap_continue & !ap_start.
  - RUN stays RUN on ap_done & ap_continue & ap_start.
  - Any state to FROZEN on finish.
  - FROZEN is left only by reset.
- mod_start_cnt increments on ap_start & ap_ready.
- mod_done_cnt increments on ap_done & ap_continue.
- mod_busy_cnt increments on every cycle spent in RUN.
- Iteration start event: cur_state==iter_start_state & iter_start_enable & !iter_start_block.
- Iteration end event: cur_state==iter_end_state & iter_end_enable & !iter_end_block.
- Loop invocation event: loop_done & loop_continue.
  - If quit_at_end=1, the event also requires cur_state==quit_state & quit_enable & !quit_block.
  - If quit_at_end=0, loop_done & loop_continue alone suffice.
- Stall cycle: loop active & cur_state==iter_start_state & iter_start_block.
  - Loop active sets on loop_start and clears on the loop invocation event.
  - If set and clear coincide, set wins.
- Counters saturate at all-ones and never wrap.
- loop_inflight is the exception: it is a plain modulo difference of the two iteration counters.
- Simultaneous events in one cycle each count independently.
- In FROZEN, all counters hold, mod_busy=0 and frozen=1.

## Timing
- All outputs are registered. An event at rising edge N is visible after edge N+1 (1-cycle latency).
- Reset values: every counter 0, mod_busy=0, frozen=0, loop active=0, FSM=IDLE.
- Reset asserted mid-transaction clears everything immediately (asynchronous). Counting resumes on the first edge after deassertion.
- finish sampled at edge N: events in that same cycle are still counted. frozen=1 after edge N.
- While reset is high, finish is ignored.

## Configuration
- HLS_MON_STALL_EN defined: stall detection logic and loop_stall_cnt register are built.
- HLS_MON_STALL_EN undefined: no stall logic is built and loop_stall_cnt is tied to 0.
- All other outputs are identical in both builds.

## Structure
- Package hls_mon_pkg holds:
  - mod_state_e (IDLE, RUN, FROZEN);
  - default CNT_W constant;
  - helper function for the saturating increment.
- One sub-module, hls_mon_sat_counter (CNT_W parameter; inc, freeze inputs; async reset), instantiated once per counter.

## Test plan
- Reset, then ap_start=1 for 1 cycle with ap_ready=1, then ap_done & ap_continue 10 cycles later -> mod_start_cnt=1, mod_done_cnt=1, mod_busy_cnt=10, mod_busy back to 0.
- STATE_W=1, cur_state==iter_start_state==iter_end_state, both enables=1, blocks=0 for 8 cycles -> loop_iter_start_cnt=8, loop_iter_end_cnt=8, loop_inflight=0.
- Same as above with iter_start_block=1 for 3 of those cycles, HLS_MON_STALL_EN defined -> loop_iter_start_cnt=5, loop_stall_cnt=3. Without the macro -> loop_stall_cnt=0.
- quit_at_end=1, loop_done & loop_continue pulse while quit_enable=0 -> loop_inv_cnt=0. Repeat with quit_enable=1 -> loop_inv_cnt=1.
- CNT_W=4, 20 iteration start events -> loop_iter_start_cnt holds 15. loop_inflight wraps modulo 16.
- finish at cycle 5 of a RUN, then 10 more active cycles -> counters frozen at their cycle-5 values, frozen=1. Reset clears all and frozen=0.
